// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle multiply/divide engine that owns the architectural HI/LO registers.
// 32-step shift-add multiply and restoring divide on magnitudes, with a sign fix-up cycle at the end.
module muldiv_hilo_unit (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_src_a,
    input  logic [31:0] i_src_b,
    input  logic        i_mthi_we,
    input  logic        i_mtlo_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_div_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [4:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_raw_a;
    logic [63:0] r_acc;
    logic        r_is_div;
    logic        r_signed;
    logic        r_sign;
    logic        r_a_neg;
    logic        r_dz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic        r_div_zero;

    logic        w_op_signed;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_acc;
    logic [32:0] w_div_shift;
    logic        w_qbit;
    logic [31:0] w_div_rem;
    logic [63:0] w_div_acc;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    always_comb begin
        w_op_signed = ~i_op[0];
        w_a_mag     = (w_op_signed && i_src_a[31]) ? (32'd0 - i_src_a) : i_src_a;
        w_b_mag     = (w_op_signed && i_src_b[31]) ? (32'd0 - i_src_b) : i_src_b;
    end

    // Multiply: add into the upper half, then shift the whole product right one place.
    always_comb begin
        w_mul_sum = {1'b0, r_acc[63:32]} + {1'b0, (r_b[0] ? r_a : 32'd0)};
        w_mul_acc = {w_mul_sum, r_acc[31:1]};
    end

    // Divide: remainder in acc[63:32], quotient bits shift into acc[31:0].
    always_comb begin
        w_div_shift = {r_acc[63:32], r_a[31]};
        w_qbit      = (w_div_shift >= {1'b0, r_b});
        w_div_rem   = w_qbit ? (w_div_shift[31:0] - r_b) : w_div_shift[31:0];
        w_div_acc   = {w_div_rem, r_acc[30:0], w_qbit};
    end

    always_comb begin
        w_prod = (r_signed && r_sign) ? (64'd0 - r_acc) : r_acc;
        w_quot = (r_signed && r_sign) ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
        w_rem  = (r_signed && r_a_neg) ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
        if (r_is_div && r_dz) begin
            w_res_hi = r_raw_a;
            w_res_lo = 32'hFFFF_FFFF;
        end else if (r_is_div) begin
            w_res_hi = w_rem;
            w_res_lo = w_quot;
        end else begin
            w_res_hi = w_prod[63:32];
            w_res_lo = w_prod[31:0];
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = i_op[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                if (r_cnt == 5'd31) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 5'd0;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_raw_a    <= 32'd0;
            r_acc      <= 64'd0;
            r_is_div   <= 1'b0;
            r_signed   <= 1'b0;
            r_sign     <= 1'b0;
            r_a_neg    <= 1'b0;
            r_dz       <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_mthi_we) begin
                        r_hi <= i_wdata;
                    end
                    if (i_mtlo_we) begin
                        r_lo <= i_wdata;
                    end
                    if (i_start) begin
                        r_a      <= w_a_mag;
                        r_b      <= w_b_mag;
                        r_raw_a  <= i_src_a;
                        r_acc    <= 64'd0;
                        r_cnt    <= 5'd0;
                        r_is_div <= i_op[1];
                        r_signed <= w_op_signed;
                        r_sign   <= w_op_signed & (i_src_a[31] ^ i_src_b[31]);
                        r_a_neg  <= w_op_signed & i_src_a[31];
                        r_dz     <= i_op[1] & (i_src_b == 32'd0);
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_acc;
                    r_b   <= {1'b0, r_b[31:1]};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_DIV: begin
                    r_acc <= w_div_acc;
                    r_a   <= {r_a[30:0], 1'b0};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_FIX: begin
                    r_hi       <= w_res_hi;
                    r_lo       <= w_res_lo;
                    r_done     <= 1'b1;
                    r_div_zero <= r_dz;
                end
                default: ;
            endcase
        end
    end

    assign o_hi       = r_hi;
    assign o_lo       = r_lo;
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = r_done;
    assign o_div_zero = r_div_zero;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit: expected HI/LO/div_zero pushed to a scoreboard at issue
// and compared when done pulses, plus latency, busy-length, MTHI/MTLO and reset checks.
module tb_muldiv_hilo_unit;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic [1:0]  i_op = 2'b00;
    logic [31:0] i_src_a = 32'd0;
    logic [31:0] i_src_b = 32'd0;
    logic        i_mthi_we = 1'b0;
    logic        i_mtlo_we = 1'b0;
    logic [31:0] i_wdata = 32'd0;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic        o_busy;
    logic        o_done;
    logic        o_div_zero;

    typedef struct packed {
        logic        dz;
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    res_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    muldiv_hilo_unit dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_src_a    (i_src_a),
        .i_src_b    (i_src_b),
        .i_mthi_we  (i_mthi_we),
        .i_mtlo_we  (i_mtlo_we),
        .i_wdata    (i_wdata),
        .o_hi       (o_hi),
        .o_lo       (o_lo),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_div_zero (o_div_zero)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic res_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb_v;
        logic [63:0] p;
        res_t        r;
        sa   = $signed(a);
        sb_v = $signed(b);
        r.dz = 1'b0;
        case (op)
            2'b00: begin
                p = sa * sb_v;
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            2'b01: begin
                p = {32'd0, a} * {32'd0, b};
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            2'b10: begin
                if (b == 32'd0) begin
                    r.dz = 1'b1; r.hi = a; r.lo = 32'hFFFF_FFFF;
                end else begin
                    p = sa / sb_v;
                    r.lo = p[31:0];
                    p = sa % sb_v;
                    r.hi = p[31:0];
                end
            end
            default: begin
                if (b == 32'd0) begin
                    r.dz = 1'b1; r.hi = a; r.lo = 32'hFFFF_FFFF;
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
        endcase
        return r;
    endfunction

    // Drive a start pulse just after an edge; the next rising edge samples it.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input res_t exp);
        i_op    = op;
        i_src_a = a;
        i_src_b = b;
        i_start = 1'b1;
        sb.push_back(exp);
    endtask

    // Waits (bounded) for done; lat counts edges after the start edge, busy_n counts busy samples.
    task automatic run_to_done(input int inj, output int lat, output int busy_n,
                               output bit lo_moved, output logic [31:0] hi_k);
        logic [31:0] lo0;
        @(posedge i_clk); #1;
        i_start   = 1'b0;
        i_mthi_we = 1'b0;
        i_mtlo_we = 1'b0;
        lat      = 0;
        busy_n   = o_busy ? 1 : 0;
        lo0      = o_lo;
        hi_k     = o_hi;
        lo_moved = 1'b0;
        while (lat < 40) begin
            if (inj != 0 && lat == inj) begin
                i_start   = 1'b1;
                i_mtlo_we = 1'b1;
                i_wdata   = 32'hDEAD_BEEF;
                i_op      = 2'b11;
                i_src_a   = 32'd9;
                i_src_b   = 32'd0;
            end
            @(posedge i_clk); #1;
            i_start   = 1'b0;
            i_mtlo_we = 1'b0;
            lat++;
            if (o_done) break;
            if (o_busy) busy_n++;
            if (o_lo !== lo0) lo_moved = 1'b1;
        end
    endtask

    task automatic test_op(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input res_t exp);
        int          lat;
        int          busy_n;
        bit          lo_moved;
        logic [31:0] hi_k;
        res_t        got;
        res_t        want;
        issue(op, a, b, exp);
        run_to_done(0, lat, busy_n, lo_moved, hi_k);
        got = {o_div_zero, o_hi, o_lo};
        want = (sb.size() != 0) ? sb.pop_front() : ~got;
        total_cnt++;
        if (got !== want) $display("FAIL %s result: got %h required %h", name, got, want);
        else pass_cnt++;
        total_cnt++;
        if (lat != 33) $display("FAIL %s latency: got %0d required 33", name, lat);
        else pass_cnt++;
        total_cnt++;
        if (busy_n != 33 || o_busy !== 1'b0)
            $display("FAIL %s busy: got %0d cycles busy_now=%b required 33/0", name, busy_n, o_busy);
        else pass_cnt++;
        @(posedge i_clk); #1;
        total_cnt++;
        if ({o_done, o_div_zero} !== 2'b00)
            $display("FAIL %s pulse width: got done=%b dz=%b required 0/0", name, o_done, o_div_zero);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge i_clk);
        #1;
        total_cnt++;
        if ({o_hi, o_lo, o_busy, o_done, o_div_zero} !== 67'd0)
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b dz=%b required all 0",
                     o_hi, o_lo, o_busy, o_done, o_div_zero);
        else pass_cnt++;
        i_reset = 1'b0;
    endtask

    task automatic test_multu_max();
        test_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'hFFFF_FFFE, 32'h1});
    endtask

    task automatic test_signed();
        test_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
        test_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        test_op("div_negb", 2'b10, 32'd17, 32'hFFFF_FFFB, {1'b0, 32'd2, 32'hFFFF_FFFD});
    endtask

    task automatic test_div_zero();
        test_op("divu_zero", 2'b11, 32'd100, 32'd0, {1'b1, 32'h64, 32'hFFFF_FFFF});
        test_op("div_zero_neg", 2'b10, 32'hFFFF_FFFB, 32'd0, {1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF});
    endtask

    task automatic test_overflow();
        test_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'h0, 32'h8000_0000});
    endtask

    task automatic test_mthi_mtlo();
        int          lat;
        int          busy_n;
        bit          lo_moved;
        logic [31:0] hi_k;
        res_t        got;
        res_t        want;
        i_mthi_we = 1'b1;
        i_wdata   = 32'h1234_5678;
        @(posedge i_clk); #1;
        i_mthi_we = 1'b0;
        total_cnt++;
        if (o_hi !== 32'h1234_5678) $display("FAIL mthi: got %h required 12345678", o_hi);
        else pass_cnt++;
        i_mtlo_we = 1'b1;
        i_wdata   = 32'h0BAD_F00D;
        @(posedge i_clk); #1;
        i_mtlo_we = 1'b0;
        total_cnt++;
        if (o_lo !== 32'h0BAD_F00D) $display("FAIL mtlo: got %h required 0badf00d", o_lo);
        else pass_cnt++;

        // mtlo and a second start injected mid-operation must both be dropped.
        issue(2'b01, 32'd3, 32'd4, {1'b0, 32'h0, 32'hC});
        run_to_done(5, lat, busy_n, lo_moved, hi_k);
        got = {o_div_zero, o_hi, o_lo};
        want = (sb.size() != 0) ? sb.pop_front() : ~got;
        total_cnt++;
        if (got !== want) $display("FAIL busy_ignore result: got %h required %h", got, want);
        else pass_cnt++;
        total_cnt++;
        if (lo_moved || lat != 33)
            $display("FAIL busy_ignore lo/latency: got moved=%0b lat=%0d required 0/33", lo_moved, lat);
        else pass_cnt++;
        @(posedge i_clk); #1;
        total_cnt++;
        if (o_busy !== 1'b0) $display("FAIL busy_ignore restart: got busy=%b required 0", o_busy);
        else pass_cnt++;

        // start with mthi_we: HI takes wdata first, then the product.
        issue(2'b00, 32'd2, 32'hFFFF_FFFC, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF8});
        i_mthi_we = 1'b1;
        i_wdata   = 32'hCAFE_F00D;
        run_to_done(0, lat, busy_n, lo_moved, hi_k);
        total_cnt++;
        if (hi_k !== 32'hCAFE_F00D) $display("FAIL start_mthi hi: got %h required cafef00d", hi_k);
        else pass_cnt++;
        got = {o_div_zero, o_hi, o_lo};
        want = (sb.size() != 0) ? sb.pop_front() : ~got;
        total_cnt++;
        if (got !== want) $display("FAIL start_mthi result: got %h required %h", got, want);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int          lat;
        int          busy_n;
        bit          lo_moved;
        logic [31:0] hi_k;
        res_t        got;
        res_t        want;
        issue(2'b11, 32'd1000, 32'd7, {1'b0, 32'd6, 32'd142});
        run_to_done(0, lat, busy_n, lo_moved, hi_k);
        got = {o_div_zero, o_hi, o_lo};
        want = (sb.size() != 0) ? sb.pop_front() : ~got;
        total_cnt++;
        if (got !== want) $display("FAIL b2b first: got %h required %h", got, want);
        else pass_cnt++;
        // Issue at the done cycle so the next edge (k+34) accepts it.
        issue(2'b01, 32'h0001_0000, 32'h0001_0000, {1'b0, 32'h1, 32'h0});
        run_to_done(0, lat, busy_n, lo_moved, hi_k);
        got = {o_div_zero, o_hi, o_lo};
        want = (sb.size() != 0) ? sb.pop_front() : ~got;
        total_cnt++;
        if (got !== want || lat != 33)
            $display("FAIL b2b second: got %h lat=%0d required %h lat=33", got, lat, want);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        i_op    = 2'b01;
        i_src_a = 32'd5;
        i_src_b = 32'd6;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (9) @(posedge i_clk);
        #2;
        i_reset = 1'b1;
        #1;
        total_cnt++;
        if ({o_hi, o_lo, o_busy, o_done, o_div_zero} !== 67'd0)
            $display("FAIL reset_mid: got hi=%h lo=%h busy=%b done=%b dz=%b required all 0",
                     o_hi, o_lo, o_busy, o_done, o_div_zero);
        else pass_cnt++;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        test_op("after_reset", 2'b01, 32'd5, 32'd6, {1'b0, 32'h0, 32'h1E});
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 8; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if (i == 1) b = {28'd0, 4'($urandom)} + 32'd1;
            test_op($sformatf("rand%0d", i), op, a, b, model(op, a, b));
        end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_signed();
        test_div_zero();
        test_overflow();
        test_mthi_mtlo();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo_unit.md
# muldiv_hilo_unit

Multi-cycle multiply/divide engine in the EX stage. It consumes the operands and HI/LO-class opcodes issued by the ID/EX pipeline register and owns the architectural HI and LO registers. It runs a 32-iteration shift-add multiply or restoring divide, and holds `busy` so the hazard unit stalls any dependent MFHI/MFLO/MTHI/MTLO or new mult/div. It also services MTHI/MTLO writes when idle.

## Interface
No parameters; all widths fixed at 32 bits.
- `clk`  in  1  pipeline clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `start`  in  1  issue pulse from ID/EX; sampled only in IDLE
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`
- `src_a`  in  32  rs value: multiplicand or dividend
- `src_b`  in  32  rt value: multiplier or divisor
- `mthi_we`  in  1  write `wdata` to HI; honoured only in IDLE
- `mtlo_we`  in  1  write `wdata` to LO; honoured only in IDLE
- `wdata`  in  32  MTHI/MTLO data
- `hi`  out  32  architectural HI; reset 0
- `lo`  out  32  architectural LO; reset 0
- `busy`  out  1  operation in flight, stall request; reset 0
- `done`  out  1  one-cycle pulse when HI/LO are updated by mult/div; reset 0
- `div_zero`  out  1  one-cycle pulse with `done` when the divisor was 0; reset 0

## Operation
- States: IDLE, MUL, DIV, FIX. Reset forces IDLE, iteration counter 0, and all outputs 0.
- IDLE + `start`:
  - Latch the magnitudes of `src_a`/`src_b`. Magnitudes use the absolute value for signed ops (MULT/DIV) and the raw value for unsigned ops.
  - Latch the result sign (a XOR b) and the dividend sign.
  - Latch the divide-by-zero flag (`src_b`==0, DIV/DIVU only).
  - Clear the 64-bit accumulator and counter.
  - Go to MUL for op[1]=0, DIV for op[1]=1.
- MUL: one shift-add step per cycle on a 64-bit product, 32 cycles, then FIX.
- DIV: one restoring step per cycle (shift remainder left, trial subtract, set quotient bit), 32 cycles, then FIX.
- FIX:
  - Signed MULT: negate the 64-bit product if the result sign is set.
  - Signed DIV: negate the quotient if the result sign is set; negate the remainder if the dividend was negative. The remainder's sign follows the dividend.
  - Write HI = product[63:32] or remainder; LO = product[31:0] or quotient.
  - Pulse `done`; pulse `div_zero` if the flag is set; return to IDLE.
- Divide by zero:
  - The operation still runs its full latency.
  - Result is forced to HI = `src_a` as latched (raw), LO = 32'hFFFFFFFF. There is no sign fix-up.
- Overflow case, DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. The magnitude arithmetic is 33-bit safe; no trap.
- `start` while not IDLE: ignored. The hazard unit must not issue it.
- `mthi_we`/`mtlo_we` while not IDLE: ignored.
- In IDLE, MTHI/MTLO writes take effect at the next edge. If asserted together with `start`, the write happens and the later mult/div result overwrites it.
- `busy` = (state != IDLE). `hi`/`lo` are registered and change only on an MTHI/MTLO write, at FIX, or on reset.

## Timing
- `start` sampled at edge k → `busy` high after edge k.
- Iterations occur on edges k+1..k+32. FIX runs on edge k+33, which updates `hi`/`lo` and asserts `done`.
- After edge k+33: `busy`=0 and `done`=1 for exactly one cycle.
- A new `start` is accepted at edge k+34 at the earliest.
- `busy` is high for 33 cycles total.
- Reset asserted mid-operation: state, counter, `hi`, `lo`, `busy`, `done`, `div_zero` go to 0 asynchronously, with no partial result. After deassert, the first accepted `start` begins a full fresh operation.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF at edge k → after edge k+33: HI=0xFFFFFFFE, LO=0x00000001, `done`=1 for one cycle, `busy` high exactly 33 cycles.
- MULT −3 (0xFFFFFFFD) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 → HI=0x00000064, LO=0xFFFFFFFF, `div_zero`=`done`=1 at edge k+33.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0x00000000, `div_zero`=0.
- MTHI 0x12345678 in IDLE → `hi`=0x12345678 next edge.
  - `mtlo_we` and a second `start` during `busy` → both ignored; LO and the result are those of the first op.
  - `start` together with `mthi_we` in IDLE → HI takes `wdata`, then the mult result.
- MULTU 5 × 6 with `reset` pulsed at cycle 10 → `busy`, `done`, `hi`, `lo` are 0 immediately.
  - A new MULTU 5 × 6 after release → LO=0x1E, HI=0 exactly 33 edges after its `start`.
